// File: rtl/core_step_ctrl_if.sv
// Pacing-controller bus: raw board inputs and core halt request in,
// advance/freeze pacing and LED status out.
interface core_step_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             btn;
  logic             mode_sel;
  logic             halt_req;
  logic             advance;
  logic             freeze;
  logic [CNT_W-1:0] step_count;
  logic             btn_db;
  logic [1:0]       state;

  modport master (
    output btn, mode_sel, halt_req,
    input  advance, freeze, step_count, btn_db, state
  );

  modport slave (
    input  btn, mode_sel, halt_req,
    output advance, freeze, step_count, btn_db, state
  );
endinterface

// File: rtl/core_step_ctrl.sv
// Execution-pacing stage for the dual-issue core: synchronises and debounces the
// step button, then issues single-cycle advance pulses in step or free-run mode.
module core_step_ctrl #(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int AUTO_PERIOD = 100_000_000,
  parameter int CNT_W       = 16
) (
  input logic             clk,
  input logic             rst,
  core_step_ctrl_if.slave bus
);
  localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TICK_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  // Terminal values sized to the counters so the compare never truncates.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(AUTO_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  logic [1:0]        sync1_reg, sync2_reg;
  logic              s_btn, s_mode;
  logic [DB_W-1:0]   db_cnt_reg;
  logic              btn_db_reg, btn_db_q_reg;
  logic              press_evt;
  state_t            state_reg, state_next;
  logic              advance_reg, advance_next;
  logic              freeze_reg;
  logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
  logic [CNT_W-1:0]  step_count_reg;

  // Bit 0 carries the button, bit 1 the run-mode switch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 2'b00;
      sync2_reg <= 2'b00;
    end else begin
      sync1_reg <= {bus.mode_sel, bus.btn};
      sync2_reg <= sync1_reg;
    end
  end

  assign s_btn  = sync2_reg[0];
  assign s_mode = sync2_reg[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_reg   <= '0;
      btn_db_reg   <= 1'b0;
      btn_db_q_reg <= 1'b0;
    end else begin
      btn_db_q_reg <= btn_db_reg;
      if (s_btn == btn_db_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_LAST) begin
        btn_db_reg <= s_btn;
        db_cnt_reg <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end
  end

  assign press_evt = btn_db_reg & ~btn_db_q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      advance_reg    <= 1'b0;
      freeze_reg     <= 1'b1;
      tick_cnt_reg   <= '0;
      step_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      advance_reg    <= advance_next;
      freeze_reg     <= ~advance_next;
      tick_cnt_reg   <= tick_cnt_next;
      step_count_reg <= step_count_reg + CNT_W'(advance_reg);
    end
  end

  // halt_req outranks every other event in IDLE and RUN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.halt_req)  state_next = HALT;
        else if (s_mode)   state_next = RUN;
      end
      RUN: begin
        if (bus.halt_req)  state_next = HALT;
        else if (!s_mode)  state_next = IDLE;
      end
      HALT: begin
        if (press_evt && !bus.halt_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    advance_next  = 1'b0;
    tick_cnt_next = tick_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (!bus.halt_req) begin
          if (s_mode)         tick_cnt_next = '0;
          else if (press_evt) advance_next  = 1'b1;
        end
      end
      RUN: begin
        if (bus.halt_req) begin
          tick_cnt_next = '0;
        end else if (s_mode) begin
          if (tick_cnt_reg == TICK_LAST) begin
            advance_next  = 1'b1;
            tick_cnt_next = '0;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        advance_next  = 1'b0;
        tick_cnt_next = tick_cnt_reg;
      end
    endcase
  end

  assign bus.advance    = advance_reg;
  assign bus.freeze     = freeze_reg;
  assign bus.step_count = step_count_reg;
  assign bus.btn_db     = btn_db_reg;
  assign bus.state      = state_reg;
endmodule

// File: tb/tb_core_step_ctrl.sv
// Scoreboard bench for core_step_ctrl: expected advance cycles are queued when
// stimulus is driven and matched against the pulses the DUT produces.
module tb_core_step_ctrl;
  localparam int DB = 4;
  localparam int AP = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_step_ctrl_if #(.CNT_W(CW)) bus1 ();
  core_step_ctrl_if #(.CNT_W(CW)) bus2 ();

  core_step_ctrl #(.DB_CYCLES(DB), .AUTO_PERIOD(AP), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  core_step_ctrl #(.DB_CYCLES(DB), .AUTO_PERIOD(1), .CNT_W(CW)) dut_fast (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   exp_q[$];
  bit   mon_en = 1'b0;
  logic exp_adv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Must be called at a negedge; returns at the negedge where cyc == t.
  task automatic go(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_db(input int start, input logic lvl, input string tag);
    int n;
    n = 0;
    while (bus1.btn_db !== lvl && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(cyc - start), 32'(DB + 2));
  endtask

  // Every cycle: advance must appear exactly on queued cycles, freeze its complement.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_adv = (exp_q.size() > 0 && exp_q[0] == cyc);
      check_eq("advance", 32'(bus1.advance), 32'(exp_adv));
      check_eq("freeze", 32'(bus1.freeze), 32'(!exp_adv));
      if (bus1.advance === 1'b1)
        $display("advance pulse at cycle %0d, step_count=%0d", cyc, bus1.step_count);
      if (exp_q.size() > 0 && exp_q[0] <= cyc) void'(exp_q.pop_front());
    end
  end

  initial begin
    int c;
    bus1.btn = 1'b0; bus1.mode_sel = 1'b0; bus1.halt_req = 1'b0;
    bus2.btn = 1'b0; bus2.mode_sel = 1'b0; bus2.halt_req = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_advance", 32'(bus1.advance), 32'd0);
    check_eq("rst_freeze", 32'(bus1.freeze), 32'd1);
    check_eq("rst_step_count", 32'(bus1.step_count), 32'd0);
    check_eq("rst_btn_db", 32'(bus1.btn_db), 32'd0);
    check_eq("rst_state", 32'(bus1.state), 32'd0);
    mon_en = 1'b1;
    $display("reset released at cycle %0d", cyc);

    // Glitch: 3 cycles high must not get through the 4-cycle debounce.
    c = cyc;
    bus1.btn = 1'b1;
    go(c + 3);
    bus1.btn = 1'b0;
    go(c + 16);
    check_eq("glitch_btn_db", 32'(bus1.btn_db), 32'd0);
    check_eq("glitch_step_count", 32'(bus1.step_count), 32'd0);
    $display("glitch pulse done at cycle %0d", cyc);

    // Step mode press: btn_db 6 edges after btn, advance one edge later.
    c = cyc;
    bus1.btn = 1'b1;
    exp_q.push_back(c + DB + 3);
    wait_db(c, 1'b1, "db_rise_latency");
    go(c + DB + 3);
    check_eq("step_freeze_low", 32'(bus1.freeze), 32'd0);
    go(c + DB + 4);
    check_eq("step_count_1", 32'(bus1.step_count), 32'd1);
    go(c + 20);
    bus1.btn = 1'b0;
    c = cyc;
    wait_db(c, 1'b0, "db_fall_latency");
    go(cyc + 2);

    c = cyc;
    bus1.btn = 1'b1;
    exp_q.push_back(c + DB + 3);
    go(c + 20);
    bus1.btn = 1'b0;
    check_eq("step_count_2", 32'(bus1.step_count), 32'd2);
    go(c + 30);
    $display("step presses done at cycle %0d", cyc);

    // Run mode: pulses every 8 cycles from entry; a mid-run press adds nothing.
    c = cyc;
    bus1.mode_sel = 1'b1;
    for (int k = 0; k < 6; k++) exp_q.push_back(c + 11 + AP * k);
    go(c + 3);
    check_eq("run_state", 32'(bus1.state), 32'd1);
    go(c + 22);
    bus1.btn = 1'b1;
    go(c + 32);
    bus1.btn = 1'b0;
    go(c + 52);
    bus1.mode_sel = 1'b0;
    go(c + 56);
    check_eq("run_exit_state", 32'(bus1.state), 32'd0);
    check_eq("run_step_count", 32'(bus1.step_count), 32'd8);
    $display("run mode done at cycle %0d", cyc);

    // Halt on the terminal tick: no pulse, HALT held while halt_req stays high.
    c = cyc;
    bus1.mode_sel = 1'b1;
    go(c + 3);
    check_eq("halt_run_state", 32'(bus1.state), 32'd1);
    go(c + 10);
    bus1.halt_req = 1'b1;
    bus1.mode_sel = 1'b0;
    go(c + 11);
    check_eq("halt_state", 32'(bus1.state), 32'd2);
    go(c + 12);
    bus1.btn = 1'b1;
    go(c + 20);
    check_eq("halt_press_state", 32'(bus1.state), 32'd2);
    bus1.btn = 1'b0;
    go(c + 27);
    bus1.halt_req = 1'b0;
    go(c + 28);
    bus1.btn = 1'b1;
    go(c + 34);
    check_eq("halt_before_release", 32'(bus1.state), 32'd2);
    go(c + 35);
    check_eq("halt_release_state", 32'(bus1.state), 32'd0);
    go(c + 40);
    bus1.btn = 1'b0;
    go(c + 50);
    check_eq("halt_step_count", 32'(bus1.step_count), 32'd8);
    $display("halt sequence done at cycle %0d", cyc);

    // Reset coincident with an advance pulse in RUN.
    c = cyc;
    bus1.mode_sel = 1'b1;
    bus1.btn = 1'b1;
    exp_q.push_back(c + 11);
    go(c + 11);
    check_eq("pre_rst_btn_db", 32'(bus1.btn_db), 32'd1);
    rst = 1'b1;
    bus1.btn = 1'b0;
    bus1.mode_sel = 1'b0;
    go(c + 12);
    rst = 1'b0;
    check_eq("mid_rst_advance", 32'(bus1.advance), 32'd0);
    check_eq("mid_rst_freeze", 32'(bus1.freeze), 32'd1);
    check_eq("mid_rst_step_count", 32'(bus1.step_count), 32'd0);
    check_eq("mid_rst_state", 32'(bus1.state), 32'd0);
    check_eq("mid_rst_btn_db", 32'(bus1.btn_db), 32'd0);
    go(c + 20);
    check_eq("post_rst_state", 32'(bus1.state), 32'd0);
    $display("mid-run reset done at cycle %0d", cyc);

    // AUTO_PERIOD=1: advance every cycle, step_count wraps.
    c = cyc;
    bus2.mode_sel = 1'b1;
    go(c + 3);
    check_eq("fast_state", 32'(bus2.state), 32'd1);
    for (int k = 0; k < 65537; k++) begin
      go(c + 4 + k);
      check_eq("fast_advance", 32'(bus2.advance), 32'd1);
      if (k == 65535) check_eq("fast_count_max", 32'(bus2.step_count), 32'h0000_ffff);
      if (k == 65536) check_eq("fast_count_wrap", 32'(bus2.step_count), 32'd0);
    end
    check_eq("fast_freeze", 32'(bus2.freeze), 32'd0);
    $display("fast run done at cycle %0d, step_count=0x%0h", cyc, bus2.step_count);

    check_eq("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
